// File: rtl/switch_ingress_buffer.sv
// Store-and-forward ingress FIFO: only whole packets reach the switch, oversize packets are dropped.
// Define INGRESS_DROP_CNT_EN to add the saturating drop_count output.
module switch_ingress_buffer #(
    parameter int WORD_WIDTH = 8,
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_WIDTH  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  sw_enable_out,
    output logic [WORD_WIDTH-1:0] sw_data_out,
    input  logic                  sw_read_in,
    output logic [CNT_WIDTH-1:0]  pkt_count
`ifdef INGRESS_DROP_CNT_EN
    ,
    output logic [15:0]           drop_count
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef logic [AW:0] ptr_t;
    typedef enum logic [1:0] {W_IDLE, W_PKT, W_DROP} wstate_e;
    typedef enum logic [1:0] {R_IDLE, R_SEND, R_GAP} rstate_e;

    logic [WORD_WIDTH:0]  mem_q [FIFO_DEPTH];
    ptr_t                 wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
    ptr_t                 wr_addr;
    wstate_e              wstate_q, wstate_d;
    rstate_e              rstate_q, rstate_d;
    logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
    logic                 full, wr_en, commit, rd_last;
    logic [WORD_WIDTH:0]  head;

    assign full = ((wr_ptr_q - rd_ptr_q) == ptr_t'(FIFO_DEPTH));
    assign head = mem_q[rd_ptr_q[AW-1:0]];

    // Write side: bytes land past commit_ptr and only become visible to the reader on eop.
    always_comb begin
        wstate_d     = wstate_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        wr_addr      = wr_ptr_q;
        wr_en        = 1'b0;
        commit       = 1'b0;
        in_ready     = !full;
        case (wstate_q)
            W_IDLE, W_DROP: begin
                if (wstate_q == W_DROP) in_ready = 1'b1;
                if (in_valid && in_ready) begin
                    if (in_sop) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + ptr_t'(1);
                        commit   = in_eop;
                        wstate_d = in_eop ? W_IDLE : W_PKT;
                    end else if (in_eop) begin
                        wstate_d = W_IDLE;
                    end
                end
            end
            W_PKT: begin
                // Full with nothing committed ahead: this packet alone fills the FIFO.
                if (full && (commit_ptr_q == rd_ptr_q)) begin
                    wr_ptr_d = commit_ptr_q;
                    wstate_d = W_DROP;
                end else if (in_valid && !full) begin
                    wr_en = 1'b1;
                    if (in_sop) wr_addr = commit_ptr_q;
                    wr_ptr_d = wr_addr + ptr_t'(1);
                    if (in_eop) begin
                        commit   = 1'b1;
                        wstate_d = W_IDLE;
                    end
                end
            end
            default: wstate_d = W_IDLE;
        endcase
        if (commit) commit_ptr_d = wr_ptr_d;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr[AW-1:0]] <= {in_eop, in_data};
    end

    always_comb begin
        rstate_d      = rstate_q;
        rd_ptr_d      = rd_ptr_q;
        rd_last       = 1'b0;
        sw_enable_out = 1'b0;
        sw_data_out   = '0;
        case (rstate_q)
            R_IDLE: if (pkt_count_q != '0) rstate_d = R_SEND;
            R_SEND: begin
                sw_enable_out = 1'b1;
                sw_data_out   = head[WORD_WIDTH-1:0];
                if (sw_read_in) begin
                    rd_ptr_d = rd_ptr_q + ptr_t'(1);
                    if (head[WORD_WIDTH]) begin
                        rd_last  = 1'b1;
                        rstate_d = R_GAP;
                    end
                end
            end
            R_GAP:   rstate_d = R_IDLE;
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        pkt_count_d = pkt_count_q;
        case ({commit, rd_last})
            2'b10:   pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
            2'b01:   pkt_count_d = pkt_count_q - CNT_WIDTH'(1);
            default: pkt_count_d = pkt_count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate_q     <= W_IDLE;
            rstate_q     <= R_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            pkt_count_q  <= '0;
        end else begin
            wstate_q     <= wstate_d;
            rstate_q     <= rstate_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign pkt_count = pkt_count_q;

`ifdef INGRESS_DROP_CNT_EN
    logic [15:0] drop_count_q;
    logic        drop_evt;

    // Counts oversize drops and packets abandoned by a fresh sop.
    assign drop_evt = (wstate_q == W_PKT) &&
                      ((wstate_d == W_DROP) || (in_valid && in_ready && in_sop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                       drop_count_q <= '0;
        else if (drop_evt && (drop_count_q != 16'hFFFF)) drop_count_q <= drop_count_q + 16'd1;
    end

    assign drop_count = drop_count_q;
`endif
endmodule
